spi_regfile_periph: RTL and testbench
=====================================

Name: spi_regfile_periph

Overview:
- Parametrised SPI (mode 0) peripheral: NUM_REGS × DATA_W control register file with write and read-back over one serial frame.
- All SPI pins are oversampled in the clk domain. Each register drives a flat output bus consumed by the output-enable/PWM logic.
- Additions over the prior generation:
  - read path on CIPO with output enable;
  - parametric register count, address width and data width;
  - frame-length and address error reporting;
  - a write strobe per commit.

Parameters:
- NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1); 1 ≤ NUM_REGS ≤ 2^ADDR_W.
- ADDR_W, 7, address field width in bits.
- DATA_W, 8, data field width and register width in bits.
- SYNC_STAGES, 2, synchroniser flops per SPI input (≥2).

Ports:
- clk  in  1  system clock; must be ≥ 8× SCLK frequency.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock, asynchronous.
- ncs  in  1  chip select, active low, asynchronous.
- copi  in  1  controller-out serial data, asynchronous.
- cipo  out  1  peripheral-out serial data (read data).
- cipo_oe  out  1  high while this peripheral drives CIPO.
- regs  out  NUM_REGS*DATA_W  flat register bus; register i occupies bits [i*DATA_W +: DATA_W].
- wr_stb  out  1  one-cycle pulse when a write commits.
- wr_addr  out  ADDR_W  address of the last committed write (valid with wr_stb, held afterwards).
- err_len  out  1  one-cycle pulse: frame ended with bit count ≠ FRAME_LEN.
- err_addr  out  1  one-cycle pulse: valid-length frame targeted address ≥ NUM_REGS.

Behaviour:
- FRAME_LEN = 1 + ADDR_W + DATA_W. Bit order is MSB first: R/W (1 = write, 0 = read), then address, then data.
- Synchronisation and edges: sclk, ncs and copi each pass through SYNC_STAGES flops. Edges are detected on the last two synchronised stages: sclk rise, sclk fall, ncs fall, ncs rise.
- FSM states and transitions:
  - IDLE → HDR on ncs fall.
  - HDR: shift copi on each sclk rise; after 1+ADDR_W bits go to DATA.
  - DATA: shift copi on each sclk rise; after DATA_W bits go to DONE.
  - DONE: any further sclk rise → OVF.
  - OVF: ignore sclk until ncs rise.
  - Any state → IDLE on ncs rise.
- Bit counter: $clog2(FRAME_LEN+1) bits. Cleared on ncs fall. Saturates in OVF; never wraps.
- Write commit happens in the cycle after ncs rise, only if the state was DONE and R/W = 1:
  - address < NUM_REGS: register updated, wr_stb = 1, wr_addr = address;
  - otherwise: no update, err_addr = 1.
- Read path:
  - In the cycle the HDR→DATA transition occurs with R/W = 0, load the out-shifter with the register (0 if address ≥ NUM_REGS) and assert cipo_oe.
  - cipo drives the shifter MSB. The shifter shifts on each sclk fall while in DATA.
  - A read to address ≥ NUM_REGS also pulses err_addr at ncs rise if the length was valid.
  - The data phase of a read frame is ignored; COPI content there does not matter.
- cipo_oe deasserts in the cycle after ncs rise. cipo = 0 whenever cipo_oe = 0.
- Frame abort: ncs rise in IDLE, HDR, DATA or OVF produces no commit and pulses err_len. A lone ncs rise with zero bits also pulses err_len.
- Simultaneous events:
  - ncs rise in the same cycle as an sclk edge: the ncs edge wins and the sclk edge is discarded.
  - ncs fall together with sclk rise: the counter clears and that bit is discarded.
- sclk edges while ncs is high are ignored.
- Reset mid-frame: FSM → IDLE, all registers → 0, shifters → 0, cipo / cipo_oe / wr_stb / err_* → 0, wr_addr → 0. Synchroniser flops reset to sclk = 0, ncs = 1, copi = 0. A frame in progress during reset is lost; no commit occurs until a fresh ncs fall.
- Latency: write visible on regs 2 cycles after the synchronised ncs rise, i.e. SYNC_STAGES+2 clk cycles after the pin edge.

Decomposition:
- Package spi_periph_pkg:
  - FSM state enum (IDLE, HDR, DATA, DONE, OVF);
  - RW_WRITE/RW_READ constants;
  - frame_len(ADDR_W, DATA_W) function.
- Sub-module spi_sync_edge: parametrised SYNC_STAGES synchroniser with rise/fall outputs and a reset value parameter. Instantiated three times.

Test Plan:
- Write 0x04 ← 0xA5 (frame 0x84A5, sclk = clk/10) → regs[39:32] = 0xA5; wr_stb is one pulse; wr_addr = 4; other registers remain 0.
- Write 0x01 ← 0x3C, then read 0x01 (frame 0x01xx) → cipo shifts 0,0,1,1,1,1,0,0 on successive sclk rises; cipo_oe is high only during the data phase.
- Write to 0x10 (≥ NUM_REGS) with data 0xFF → no register change; err_addr pulses; wr_stb stays 0.
- Abort after 9 bits, then a 17-bit frame → err_len pulses for each; registers unchanged; the next valid write to 0x00 ← 0x55 succeeds.
- Assert rst at bit 12 of a write to 0x02 → all outputs 0; a subsequent valid write to 0x02 ← 0x0F lands correctly.
- Parameter sweep NUM_REGS = 16, ADDR_W = 4, DATA_W = 16: write 0xF ← 0xBEEF, read it back → 0xBEEF on cipo MSB first.

Source files
------------

// File: rtl/spi_periph_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_periph_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_OVF  = 3'd4
  } state_e;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_len(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with rise/fall strobes
// taken from the synchronised value and its one-cycle-delayed copy.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  // Next value of the synchroniser chain and the edge-detect history flop
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser and history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign dout = sync_q[STAGES-1];
  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral: one frame = R/W bit, address, data (MSB first),
// giving write and read-back access to a NUM_REGS x DATA_W register file.
module spi_regfile_periph
  import spi_periph_pkg::*;
#(
  parameter int NUM_REGS    = 5,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         ncs,
  input  logic                         copi,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_stb,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         err_len,
  output logic                         err_addr
);

  localparam int FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]  HDR_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0]  HDR_BITS   = CNT_W'(ADDR_W + 1);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ncs_s, ncs_rise, ncs_fall;
  logic copi_s, copi_rise, copi_fall;
  logic unused_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(sclk), .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .din(ncs), .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .din(copi), .dout(copi_s), .rise(copi_rise), .fall(copi_fall)
  );

  assign unused_s = ^{sclk_s, copi_rise, copi_fall};

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]     sh_q, sh_d;
  logic [DATA_W-1:0]        out_q, out_d;
  logic                     oe_q, oe_d;
  logic                     cipo_q, cipo_d;
  logic                     end_q, end_d;
  logic                     end_ok_q, end_ok_d;
  logic [DATA_W-1:0]        regs_q [NUM_REGS];
  logic [DATA_W-1:0]        regs_d [NUM_REGS];
  logic                     wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic                     err_len_q, err_len_d;
  logic                     err_addr_q, err_addr_d;

  logic [ADDR_W:0]          hdr_word;
  logic [DATA_W-1:0]        rd_val;
  logic                     fr_rw;
  logic [ADDR_W-1:0]        fr_addr;
  logic [DATA_W-1:0]        fr_data;
  logic                     fr_addr_ok;

  // Header as it will look once the current COPI bit is shifted in, and the read mux
  always_comb begin
    hdr_word = {sh_q[ADDR_W-1:0], copi_s};
    rd_val   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val = (hdr_word[ADDR_W-1:0] == ADDR_W'(i)) ? regs_q[i] : rd_val;
    end
  end

  // Frame FSM: bit capture, counter and read shifter; ncs edges take priority over sclk
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    out_d    = out_q;
    oe_d     = oe_q;
    end_d    = 1'b0;
    end_ok_d = 1'b0;
    if (ncs_rise) begin
      state_d  = ST_IDLE;
      oe_d     = 1'b0;
      out_d    = '0;
      end_d    = 1'b1;
      end_ok_d = (state_q == ST_DONE);
    end else if (ncs_fall) begin
      state_d = ST_HDR;
      cnt_d   = '0;
    end else if (sclk_rise && !ncs_s) begin
      case (state_q)
        ST_HDR: begin
          sh_d  = {sh_q[FRAME_LEN-2:0], copi_s};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == HDR_LAST) begin
            state_d = ST_DATA;
            if (hdr_word[ADDR_W] == RW_READ) begin
              out_d = rd_val;
              oe_d  = 1'b1;
            end else begin
              out_d = out_q;
              oe_d  = oe_q;
            end
          end else begin
            state_d = ST_HDR;
          end
        end
        ST_DATA: begin
          sh_d    = {sh_q[FRAME_LEN-2:0], copi_s};
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == FRAME_LAST) ? ST_DONE : ST_DATA;
        end
        ST_DONE: begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_OVF;
        end
        ST_OVF:  state_d = ST_OVF;
        default: state_d = state_q;
      endcase
    end else if (sclk_fall && !ncs_s && (state_q == ST_DATA) && (cnt_q > HDR_BITS)) begin
      // The first fall after the header is skipped so the MSB is sampled on the next rise
      out_d = {out_q[DATA_W-2:0], 1'b0};
    end else begin
      state_d = state_q;
    end
    cipo_d = oe_d & out_d[DATA_W-1];
  end

  // Commit stage, one cycle after the synchronised ncs rise
  always_comb begin
    fr_rw      = sh_q[FRAME_LEN-1];
    fr_addr    = sh_q[DATA_W +: ADDR_W];
    fr_data    = sh_q[DATA_W-1:0];
    fr_addr_ok = ({1'b0, fr_addr} < NUM_REGS_W);
    regs_d     = regs_q;
    wr_stb_d   = 1'b0;
    wr_addr_d  = wr_addr_q;
    err_len_d  = 1'b0;
    err_addr_d = 1'b0;
    if (end_q) begin
      if (!end_ok_q) begin
        err_len_d = 1'b1;
      end else if (!fr_addr_ok) begin
        err_addr_d = 1'b1;
      end else if (fr_rw == RW_WRITE) begin
        wr_stb_d  = 1'b1;
        wr_addr_d = fr_addr;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (fr_addr == ADDR_W'(i)) begin
            regs_d[i] = fr_data;
          end else begin
            regs_d[i] = regs_q[i];
          end
        end
      end else begin
        wr_stb_d = 1'b0;
      end
    end else begin
      wr_stb_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      out_q      <= '0;
      oe_q       <= 1'b0;
      cipo_q     <= 1'b0;
      end_q      <= 1'b0;
      end_ok_q   <= 1'b0;
      regs_q     <= '{default: '0};
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      err_len_q  <= 1'b0;
      err_addr_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      out_q      <= out_d;
      oe_q       <= oe_d;
      cipo_q     <= cipo_d;
      end_q      <= end_d;
      end_ok_q   <= end_ok_d;
      regs_q     <= regs_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      err_len_q  <= err_len_d;
      err_addr_q <= err_addr_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign cipo     = cipo_q;
  assign cipo_oe  = oe_q;
  assign wr_stb   = wr_stb_q;
  assign wr_addr  = wr_addr_q;
  assign err_len  = err_len_q;
  assign err_addr = err_addr_q;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Bench for spi_regfile_periph: default build (a) and a 16x16 / 4-bit-address build (b)
// share sclk/copi; each has its own chip select.
module tb_spi_regfile_periph;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic copi = 1'b0;
  logic ncs_a = 1'b1;
  logic ncs_b = 1'b1;

  logic         cipo_a, oe_a, wr_stb_a, err_len_a, err_addr_a;
  logic [39:0]  regs_a;
  logic [6:0]   wr_addr_a;
  logic         cipo_b, oe_b, wr_stb_b, err_len_b, err_addr_b;
  logic [255:0] regs_b;
  logic [3:0]   wr_addr_b;

  int checks = 0;
  int errors = 0;
  int n_wr [2];
  int n_el [2];
  int n_ea [2];

  // Reference model: register contents and last write address per build
  logic [15:0] mdl [2][16];
  int          mdl_waddr [2];

  spi_regfile_periph u_dut_a (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs_a), .copi(copi),
    .cipo(cipo_a), .cipo_oe(oe_a), .regs(regs_a), .wr_stb(wr_stb_a),
    .wr_addr(wr_addr_a), .err_len(err_len_a), .err_addr(err_addr_a)
  );

  spi_regfile_periph #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(16), .SYNC_STAGES(2)) u_dut_b (
    .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs_b), .copi(copi),
    .cipo(cipo_b), .cipo_oe(oe_b), .regs(regs_b), .wr_stb(wr_stb_b),
    .wr_addr(wr_addr_b), .err_len(err_len_b), .err_addr(err_addr_b)
  );

  always #5 clk = ~clk;

  // Count cycles each pulse output is high
  always @(posedge clk) begin
    n_wr[0] <= n_wr[0] + int'(wr_stb_a);
    n_el[0] <= n_el[0] + int'(err_len_a);
    n_ea[0] <= n_ea[0] + int'(err_addr_a);
    n_wr[1] <= n_wr[1] + int'(wr_stb_b);
    n_el[1] <= n_el[1] + int'(err_len_b);
    n_ea[1] <= n_ea[1] + int'(err_addr_b);
  end

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [255:0] model_flat(input int w);
    logic [255:0] f;
    int dw, nregs;
    dw    = (w != 0) ? 16 : 8;
    nregs = (w != 0) ? 16 : 5;
    f = '0;
    for (int i = 0; i < nregs; i++) f = f | (256'(mdl[w][i]) << (i * dw));
    return f;
  endfunction

  task automatic check_regs(input int w, input string tag);
    check_eq($sformatf("%s_regs%0d", tag, w), (w != 0) ? regs_b : 256'(regs_a), model_flat(w));
    check_eq($sformatf("%s_wr_addr%0d", tag, w), (w != 0) ? 256'(wr_addr_b) : 256'(wr_addr_a),
             256'(mdl_waddr[w]));
  endtask

  // Send nbits of word (MSB first) to build w and check everything against the model
  task automatic do_frame(input int w, input int nbits, input logic [31:0] word, input string tag);
    int aw, dw, nregs, flen, hdr, addr, oe_bad;
    int wr0, el0, ea0, exp_wr, exp_el, exp_ea;
    logic rw, cur_oe, cur_cipo, exp_oe;
    logic [15:0] data, rd, exp_rd;
    aw    = (w != 0) ? 4 : 7;
    dw    = (w != 0) ? 16 : 8;
    nregs = (w != 0) ? 16 : 5;
    flen  = 1 + aw + dw;
    hdr   = 1 + aw;
    rw    = (nbits > 0) ? word[nbits-1] : 1'b0;
    addr  = int'((word >> dw) & ((32'd1 << aw) - 32'd1));
    data  = 16'(word & ((32'd1 << dw) - 32'd1));
    wr0 = n_wr[w]; el0 = n_el[w]; ea0 = n_ea[w];
    rd = '0;
    oe_bad = 0;
    @(negedge clk);
    if (w != 0) ncs_b = 1'b0; else ncs_a = 1'b0;
    wait_clk(5);
    for (int k = 0; k < nbits; k++) begin
      copi = word[nbits-1-k];
      wait_clk(5);
      cur_oe   = (w != 0) ? oe_b : oe_a;
      cur_cipo = (w != 0) ? cipo_b : cipo_a;
      exp_oe   = (k >= hdr) && (rw == 1'b0);
      if (cur_oe !== exp_oe) oe_bad++;
      if (k >= hdr && k < flen) rd = {rd[14:0], cur_cipo};
      sclk = 1'b1;
      wait_clk(5);
      sclk = 1'b0;
    end
    wait_clk(5);
    if (w != 0) ncs_b = 1'b1; else ncs_a = 1'b1;
    wait_clk(10);

    exp_wr = 0; exp_el = 0; exp_ea = 0; exp_rd = '0;
    if (nbits != flen) exp_el = 1;
    else if (addr >= nregs) exp_ea = 1;
    else if (rw) begin
      exp_wr = 1;
      mdl[w][addr] = data;
      mdl_waddr[w] = addr;
    end else begin
      exp_rd = mdl[w][addr];
    end

    check_eq({tag, "_wr_stb"},   256'(n_wr[w] - wr0), 256'(exp_wr));
    check_eq({tag, "_err_len"},  256'(n_el[w] - el0), 256'(exp_el));
    check_eq({tag, "_err_addr"}, 256'(n_ea[w] - ea0), 256'(exp_ea));
    check_eq({tag, "_oe_phase"}, 256'(oe_bad), 256'(0));
    if (nbits == flen && !rw) check_eq({tag, "_rdata"}, 256'(rd), 256'(exp_rd));
    check_eq({tag, "_idle_oe_cipo"}, (w != 0) ? 256'({oe_b, cipo_b}) : 256'({oe_a, cipo_a}), 256'(0));
    check_regs(w, tag);
  endtask

  initial begin
    int w, nb, aw, dw, flen;
    logic [31:0] word;
    for (int i = 0; i < 16; i++) begin
      mdl[0][i] = '0;
      mdl[1][i] = '0;
    end
    mdl_waddr[0] = 0;
    mdl_waddr[1] = 0;

    wait_clk(6);
    check_eq("rst_outs_a", {regs_a, wr_addr_a, cipo_a, oe_a, wr_stb_a, err_len_a, err_addr_a}, 256'(0));
    check_eq("rst_outs_b", {regs_b[250:0], cipo_b, oe_b, wr_stb_b, err_len_b, err_addr_b}, 256'(0));
    rst = 1'b0;
    wait_clk(5);
    check_regs(0, "post_rst");

    do_frame(0, 16, 32'h84A5, "wr4_a5");
    do_frame(0, 16, 32'h813C, "wr1_3c");
    do_frame(0, 16, 32'h015A, "rd1");
    do_frame(0, 16, 32'h90FF, "wr_oob");
    do_frame(0, 16, 32'h1000, "rd_oob");
    do_frame(0,  9, 32'h1FF,  "abort9");
    do_frame(0, 17, 32'h1FFFF, "len17");
    do_frame(0,  0, 32'h0,    "len0");
    do_frame(0, 16, 32'h8055, "wr0_55");

    // Reset part-way through a write to register 2
    begin
      int el0;
      el0 = n_el[0];
      @(negedge clk);
      ncs_a = 1'b0;
      wait_clk(5);
      for (int k = 0; k < 12; k++) begin
        copi = (32'h82C3 >> (15 - k)) & 32'd1;
        wait_clk(5);
        sclk = 1'b1;
        wait_clk(5);
        sclk = 1'b0;
      end
      rst = 1'b1;
      wait_clk(2);
      ncs_a = 1'b1;
      wait_clk(10);
      rst = 1'b0;
      wait_clk(10);
      for (int i = 0; i < 16; i++) begin
        mdl[0][i] = '0;
        mdl[1][i] = '0;
      end
      mdl_waddr[0] = 0;
      mdl_waddr[1] = 0;
      check_eq("midrst_outs", {regs_a, wr_addr_a, cipo_a, oe_a, wr_stb_a, err_len_a, err_addr_a}, 256'(0));
      check_eq("midrst_no_err", 256'(n_el[0] - el0), 256'(0));
    end
    do_frame(0, 16, 32'h820F, "wr2_0f");

    do_frame(1, 21, 32'h1FBEEF, "b_wrF");
    do_frame(1, 21, 32'h0F1234, "b_rdF");

    for (int it = 0; it < 40; it++) begin
      w    = int'($urandom_range(0, 1));
      aw   = (w != 0) ? 4 : 7;
      dw   = (w != 0) ? 16 : 8;
      flen = 1 + aw + dw;
      word = ({31'd0, 1'($urandom_range(0, 1))} << (aw + dw))
           | ((($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, (1 << aw) - 1))
                                            : 32'($urandom_range(0, (w != 0) ? 15 : 4))) << dw)
           | (32'($urandom) & ((32'd1 << dw) - 32'd1));
      nb = flen;
      if ($urandom_range(0, 7) == 0) begin
        nb = int'($urandom_range(0, flen + 3));
        if (nb == flen) nb = flen + 1;
        word = $urandom;
      end
      do_frame(w, nb, word, $sformatf("rnd%0d", it));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
